backtrack_ctrl: RTL and testbench
=================================

// Module: backtrack_ctrl
//
// PURPOSE
// Backtracking initiator for the trace table stack in the DPLL SAT core. On a
// conflict it pops trace entries: forced (F) entries are unassigned in the
// variable-assignment memory; the first decision (D) entry is flipped, and the
// flipped value is pushed back as a forced entry. It reports done, UNSAT when
// the stack drains with no decision left, or error on a handshake timeout.
//
// PARAMETERS
// VAR_W        9    variable index width (matches trace entry variable field)
// CNT_W        8    width of unassign_cnt
// TIMEOUT_CYC  16   max cycles to wait for tt_done before error
//
// PORTS
// clk           in   1      clock
// reset         in   1      synchronous, active-high reset
// start         in   1      conflict detected; begin backtrack (sampled in IDLE only)
// busy          out  1      high in every state except IDLE
// done          out  1      1-cycle pulse: flip pushed successfully
// unsat         out  1      1-cycle pulse: no decision left on stack
// error         out  1      1-cycle pulse: tt_done timeout
// flip_var      out  VAR_W  flipped variable; valid from done pulse until next start
// flip_val      out  1      new (forced) value of flip_var
// unassign_cnt  out  CNT_W  forced entries unassigned this run (saturating)
// tt_pop        out  1      1-cycle pop request to trace table
// tt_push       out  1      1-cycle push request to trace table
// tt_type       out  1      push entry type, D=0/F=1 (always 1 when pushing)
// tt_val        out  1      push entry value
// tt_var        out  VAR_W  push entry variable
// tt_done       in   1      trace table completion pulse for pop/push
// tt_type_in    in   1      popped entry type, valid with tt_done
// tt_val_in     in   1      popped entry value, valid with tt_done
// tt_var_in     in   VAR_W  popped entry variable, valid with tt_done
// tt_empty      in   1      trace table holds no entries
// asg_we        out  1      assignment-memory write strobe (1 cycle)
// asg_var       out  VAR_W  assignment-memory address
// asg_data      out  2      00 unassigned, 10 false, 11 true
//
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0, including flip_var, flip_val and
//   unassign_cnt. Reset mid-operation aborts at once; no pending strobes.
// - FSM: IDLE, POP, WAIT_POP, CHECK, PUSH, WAIT_PUSH, FIN, UNSAT, ERR.
// - IDLE: start & ~tt_empty -> POP; clear unassign_cnt.
//   start & tt_empty -> UNSAT. start is ignored in all other states.
// - POP: tt_pop=1 for exactly one cycle; clear timer -> WAIT_POP.
// - WAIT_POP: on tt_done, latch type/val/var -> CHECK. Timer increments each
//   cycle without tt_done; timer==TIMEOUT_CYC-1 with no tt_done -> ERR.
// - CHECK: asg_we=1, asg_var=latched var.
//   Type F: asg_data=00; unassign_cnt+1 (saturating at all-ones);
//   next POP if ~tt_empty, else UNSAT.
//   Type D: asg_data={1,~val}; flip_var=var, flip_val=~val -> PUSH.
// - PUSH: tt_push=1 for one cycle with tt_type=1, tt_val=flip_val,
//   tt_var=flip_var; clear timer -> WAIT_PUSH.
// - WAIT_PUSH: tt_done -> FIN; same timeout rule as WAIT_POP -> ERR.
// - FIN/UNSAT/ERR: assert done/unsat/error for one cycle -> IDLE.
// - tt_pop and tt_push are never both high. Each has at most one outstanding
//   request. A tt_done that arrives in any state other than WAIT_* is ignored.
// - Latency, single decision on top, tt_done 1 cycle after request:
//   start to done = 7 cycles.
//   Each extra forced entry adds 3 cycles (POP, WAIT_POP, CHECK).
// - tt_type/tt_val/tt_var hold their last driven values outside PUSH.
//
// TESTING
// 1. Stack [D v5=1]; start -> asg write v5=10; push (F,0,5); done;
//    flip_var=5, flip_val=0, unassign_cnt=0.
// 2. Stack bottom->top [D v3=0, F v7=1, F v9=0] -> unassign v9 then v7 (00);
//    then v3=11; push (F,1,3); unassign_cnt=2; done.
// 3. Stack [F v1=1, F v2=0] -> both unassigned; unsat pulse; no tt_push;
//    unassign_cnt=2.
// 4. tt_empty=1 at start -> unsat 1 cycle later; no tt_pop; no asg_we.
// 5. tt_done withheld after pop -> error pulse TIMEOUT_CYC cycles after WAIT_POP
//    entry; then IDLE with busy=0.
// 6. Reset asserted in WAIT_PUSH -> next cycle all outputs 0. A second start
//    while busy is ignored: exactly one done per run.

Source files
------------

// File: rtl/backtrack_ctrl.sv
// backtrack_ctrl: conflict backtracking over the DPLL trace table stack.
// Unassigns forced entries, flips the first decision, pushes it back forced.
module backtrack_ctrl #(
    parameter int VAR_W       = 9,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             unsat,
    output logic             error,
    output logic [VAR_W-1:0] flip_var,
    output logic             flip_val,
    output logic [CNT_W-1:0] unassign_cnt,
    output logic             tt_pop,
    output logic             tt_push,
    output logic             tt_type,
    output logic             tt_val,
    output logic [VAR_W-1:0] tt_var,
    input  logic             tt_done,
    input  logic             tt_type_in,
    input  logic             tt_val_in,
    input  logic [VAR_W-1:0] tt_var_in,
    input  logic             tt_empty,
    output logic             asg_we,
    output logic [VAR_W-1:0] asg_var,
    output logic [1:0]       asg_data
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POP,
        S_WAIT_POP,
        S_CHECK,
        S_PUSH,
        S_WAIT_PUSH,
        S_FIN,
        S_UNSAT,
        S_ERR
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [TMR_W-1:0] timer;
    logic             lat_type;
    logic             lat_val;
    logic [VAR_W-1:0] lat_var;
    logic             timeout;

    assign timeout = (timer == TMR_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nx = state;
        busy     = (state != S_IDLE);
        done     = 1'b0;
        unsat    = 1'b0;
        error    = 1'b0;
        tt_pop   = 1'b0;
        tt_push  = 1'b0;
        asg_we   = 1'b0;
        asg_var  = '0;
        asg_data = 2'b00;
        unique case (state)
            S_IDLE: begin
                if (start)
                    state_nx = tt_empty ? S_UNSAT : S_POP;
            end
            S_POP: begin
                tt_pop   = 1'b1;
                state_nx = S_WAIT_POP;
            end
            S_WAIT_POP: begin
                if (tt_done)
                    state_nx = S_CHECK;
                else if (timeout)
                    state_nx = S_ERR;
            end
            S_CHECK: begin
                asg_we  = 1'b1;
                asg_var = lat_var;
                if (lat_type) begin
                    asg_data = 2'b00;
                    state_nx = tt_empty ? S_UNSAT : S_POP;
                end else begin
                    asg_data = {1'b1, ~lat_val};
                    state_nx = S_PUSH;
                end
            end
            S_PUSH: begin
                tt_push  = 1'b1;
                state_nx = S_WAIT_PUSH;
            end
            S_WAIT_PUSH: begin
                if (tt_done)
                    state_nx = S_FIN;
                else if (timeout)
                    state_nx = S_ERR;
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            S_UNSAT: begin
                unsat    = 1'b1;
                state_nx = S_IDLE;
            end
            S_ERR: begin
                error    = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            timer        <= '0;
            lat_type     <= 1'b0;
            lat_val      <= 1'b0;
            lat_var      <= '0;
            flip_var     <= '0;
            flip_val     <= 1'b0;
            unassign_cnt <= '0;
            tt_type      <= 1'b0;
            tt_val       <= 1'b0;
            tt_var       <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start)
                        unassign_cnt <= '0;
                end
                S_POP, S_PUSH: timer <= '0;
                S_WAIT_POP: begin
                    if (tt_done) begin
                        lat_type <= tt_type_in;
                        lat_val  <= tt_val_in;
                        lat_var  <= tt_var_in;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WAIT_PUSH: begin
                    if (!tt_done)
                        timer <= timer + 1'b1;
                end
                S_CHECK: begin
                    if (lat_type) begin
                        if (unassign_cnt != '1)
                            unassign_cnt <= unassign_cnt + 1'b1;
                    end else begin
                        // push bundle is registered here so it holds after PUSH
                        flip_var <= lat_var;
                        flip_val <= ~lat_val;
                        tt_type  <= 1'b1;
                        tt_val   <= ~lat_val;
                        tt_var   <= lat_var;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_backtrack_ctrl.sv
// tb_backtrack_ctrl: directed and randomized runs of backtrack_ctrl against
// a stack-level model of DPLL backtracking and an emulated trace table.
module tb_backtrack_ctrl;

    localparam int VAR_W = 9;
    localparam int CNT_W = 8;
    localparam int TMO   = 16;

    typedef struct packed {
        logic             f;
        logic             b;
        logic [VAR_W-1:0] v;
    } ent_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             busy, done, unsat, error;
    logic [VAR_W-1:0] flip_var;
    logic             flip_val;
    logic [CNT_W-1:0] unassign_cnt;
    logic             tt_pop, tt_push, tt_type, tt_val;
    logic [VAR_W-1:0] tt_var;
    logic             tt_done, tt_type_in, tt_val_in;
    logic [VAR_W-1:0] tt_var_in;
    logic             tt_empty;
    logic             asg_we;
    logic [VAR_W-1:0] asg_var;
    logic [1:0]       asg_data;

    backtrack_ctrl #(
        .VAR_W(VAR_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .unsat(unsat), .error(error),
        .flip_var(flip_var), .flip_val(flip_val),
        .unassign_cnt(unassign_cnt),
        .tt_pop(tt_pop), .tt_push(tt_push),
        .tt_type(tt_type), .tt_val(tt_val), .tt_var(tt_var),
        .tt_done(tt_done), .tt_type_in(tt_type_in),
        .tt_val_in(tt_val_in), .tt_var_in(tt_var_in),
        .tt_empty(tt_empty),
        .asg_we(asg_we), .asg_var(asg_var), .asg_data(asg_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic f, input logic b, input int v);
        mk = '{f: f, b: b, v: VAR_W'(v)};
    endfunction

    // trace table emulator, owned by one process
    ent_t tbl[$];
    ent_t init_stk[$];
    bit   flush = 1'b0;
    bit   stray = 1'b0;
    bit   rnd_dly = 1'b0;
    int   hold = 0;
    int   n_overlap = 0;
    int   n_both = 0;

    initial begin
        ent_t e;
        ent_t pe;
        bit   pend;
        bit   pk_pop;
        int   wt;
        tt_done = 1'b0; tt_type_in = 1'b0; tt_val_in = 1'b0;
        tt_var_in = '0; tt_empty = 1'b1;
        pend = 1'b0; pk_pop = 1'b0; wt = 0; pe = '0;
        forever begin
            @(posedge clk); #1;
            tt_done = stray;
            if (flush || reset) begin
                pend = 1'b0;
                if (flush) tbl = init_stk;
            end else if (pend && wt > 0) begin
                wt--;
                if (wt == 0) begin
                    pend    = 1'b0;
                    tt_done = 1'b1;
                    if (pk_pop) begin
                        e = (tbl.size() > 0) ? tbl.pop_back() : '0;
                        tt_type_in = e.f;
                        tt_val_in  = e.b;
                        tt_var_in  = e.v;
                    end else begin
                        tbl.push_back(pe);
                    end
                end
            end
            if (tt_pop && tt_push) n_both++;
            if (tt_pop || tt_push) begin
                if (pend) n_overlap++;
                pend   = 1'b1;
                pk_pop = tt_pop;
                pe     = '{f: tt_type, b: tt_val, v: tt_var};
                if ((hold == 1 && tt_pop) || (hold == 2 && tt_push))
                    wt = -1;
                else if (rnd_dly)
                    wt = 1 + $urandom_range(0, 3);
                else
                    wt = 1;
            end
            tt_empty = (tbl.size() == 0);
        end
    end

    // observed side effects, recorded for later comparison
    logic [VAR_W+1:0] obs_asg[$];
    ent_t             obs_push[$];
    int               n_pop = 0;
    int               n_done = 0;
    int               n_err = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (asg_we) obs_asg.push_back({asg_var, asg_data});
            if (tt_push) obs_push.push_back('{f: tt_type, b: tt_val, v: tt_var});
            if (tt_pop) n_pop++;
            if (done) n_done++;
            if (error) n_err++;
        end
    end

    task automatic wait_evt(input int budget, output int kind, output int at);
        kind = 0;
        at   = 0;
        for (int i = 0; i < budget && kind == 0; i++) begin
            if (done) kind = 1;
            else if (unsat) kind = 2;
            else if (error) kind = 3;
            if (kind != 0) at = cyc;
            else @(negedge clk);
        end
    endtask

    task automatic load();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
    endtask

    // one backtrack run checked against the stack model of init_stk
    task automatic run(input int budget, input bit lat_ok, input bit again);
        logic [VAR_W+1:0] exp_asg[$];
        ent_t             exp_tbl[$];
        logic [VAR_W-1:0] fv;
        logic             fb;
        int n_f = 0;
        int found = 0;
        int kind, at, s, a0, p0, q0, d0, e_kind;
        fv = '0;
        fb = 1'b0;
        for (int i = init_stk.size() - 1; i >= 0; i--) begin
            if (found == 0) begin
                if (init_stk[i].f) begin
                    n_f++;
                    exp_asg.push_back({init_stk[i].v, 2'b00});
                end else begin
                    found = 1;
                    fv = init_stk[i].v;
                    fb = ~init_stk[i].b;
                    exp_asg.push_back({init_stk[i].v, 1'b1, fb});
                    for (int j = 0; j < i; j++) exp_tbl.push_back(init_stk[j]);
                    exp_tbl.push_back('{f: 1'b1, b: fb, v: fv});
                end
            end
        end
        if (hold == 1 && init_stk.size() > 0) e_kind = 3;
        else if (hold == 2 && found == 1) e_kind = 3;
        else e_kind = (found == 1) ? 1 : 2;

        load();
        a0 = obs_asg.size();
        p0 = obs_push.size();
        q0 = n_pop;
        d0 = n_done;
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        if (again) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_evt(budget, kind, at);
        check("outcome", kind, e_kind);
        if (kind == e_kind && kind == 1 && lat_ok)
            check("lat_done", at - s + 1, 7 + 3 * n_f);
        if (kind == e_kind && kind == 2 && lat_ok)
            check("lat_unsat", at - s + 1, 2 + 3 * n_f);
        if (kind == e_kind && kind == 3 && hold == 1)
            check("err_gap", at - (s + 2), TMO);
        @(negedge clk);
        check("busy_after", 32'(busy), 0);
        repeat (again ? 12 : 1) @(negedge clk);
        #1;
        if (e_kind != 3) begin
            check("cnt", 32'(unassign_cnt), (n_f > 255) ? 255 : n_f);
            check("asg_n", obs_asg.size() - a0, exp_asg.size());
            for (int i = 0; i < exp_asg.size() && a0 + i < obs_asg.size(); i++)
                check("asg", 32'(obs_asg[a0 + i]), 32'(exp_asg[i]));
            check("pops", n_pop - q0, n_f + found);
            check("pushes", obs_push.size() - p0, found);
            check("done_n", n_done - d0, found);
            if (found == 1) begin
                if (obs_push.size() > p0)
                    check("push_ent", 32'(obs_push[p0]), 32'(exp_tbl[$]));
                check("flip_var", 32'(flip_var), 32'(fv));
                check("flip_val", 32'(flip_val), 32'(fb));
            end
            check("tbl_n", tbl.size(), exp_tbl.size());
            for (int i = 0; i < exp_tbl.size() && i < tbl.size(); i++)
                check("tbl", 32'(tbl[i]), 32'(exp_tbl[i]));
        end
        check("overlap", n_overlap, 0);
        check("pop_push_both", n_both, 0);
    endtask

    initial begin
        int a0, q0, e0, k;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_status", 32'({busy, done, unsat, error, tt_pop, tt_push,
                                 tt_type, tt_val, asg_we, flip_val}), 0);
        check("rst_data", 32'({flip_var, unassign_cnt, tt_var}), 0);
        check("rst_asg", 32'({asg_var, asg_data}), 0);
        reset = 1'b0;
        @(negedge clk);

        // single decision on top
        init_stk.delete();
        init_stk.push_back(mk(0, 1, 5));
        run(40, 1'b1, 1'b0);

        // two forced entries above a decision
        init_stk.delete();
        init_stk.push_back(mk(0, 0, 3));
        init_stk.push_back(mk(1, 1, 7));
        init_stk.push_back(mk(1, 0, 9));
        run(60, 1'b1, 1'b0);

        // only forced entries
        init_stk.delete();
        init_stk.push_back(mk(1, 1, 1));
        init_stk.push_back(mk(1, 0, 2));
        run(60, 1'b1, 1'b0);

        // empty stack
        init_stk.delete();
        run(20, 1'b1, 1'b0);

        // pop completion withheld
        init_stk.delete();
        init_stk.push_back(mk(0, 1, 5));
        hold = 1;
        run(60, 1'b1, 1'b0);
        hold = 0;

        // push completion withheld
        init_stk.delete();
        init_stk.push_back(mk(0, 1, 6));
        init_stk.push_back(mk(1, 0, 4));
        hold = 2;
        run(80, 1'b1, 1'b0);
        hold = 0;

        // restart while busy is ignored
        init_stk.delete();
        init_stk.push_back(mk(0, 1, 11));
        init_stk.push_back(mk(1, 1, 12));
        run(60, 1'b1, 1'b1);

        // stray completion in IDLE
        a0 = obs_asg.size();
        q0 = n_pop;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (4) @(negedge clk);
        check("stray_busy", 32'(busy), 0);
        check("stray_asg", obs_asg.size() - a0, 0);
        check("stray_pop", n_pop - q0, 0);

        // reset while waiting for push completion
        init_stk.delete();
        init_stk.push_back(mk(0, 0, 42));
        hold = 2;
        load();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!tt_push && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("push_seen", 32'(tt_push), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_status", 32'({busy, done, unsat, error, tt_pop, tt_push,
                                     tt_type, tt_val, asg_we, flip_val}), 0);
        check("rst_mid_data", 32'({flip_var, unassign_cnt, tt_var}), 0);
        check("rst_mid_asg", 32'({asg_var, asg_data}), 0);
        reset = 1'b0;
        hold = 0;
        e0 = n_err;
        repeat (TMO + 4) @(negedge clk);
        check("rst_no_err", n_err - e0, 0);
        check("rst_idle", 32'(busy), 0);

        // unassign counter saturation
        init_stk.delete();
        init_stk.push_back(mk(0, 1, 300));
        for (int i = 0; i < 260; i++)
            init_stk.push_back(mk(1, i[0], i + 1));
        run(3 * 270 + 50, 1'b1, 1'b0);

        // randomized stacks and completion delays
        for (int r = 0; r < 40; r++) begin
            int sz;
            sz = $urandom_range(0, 6);
            init_stk.delete();
            for (int i = 0; i < sz; i++)
                init_stk.push_back(mk($urandom_range(0, 2) != 0,
                                      1'($urandom), $urandom_range(0, 511)));
            rnd_dly = r[0];
            run(20 * (sz + 2) + 40, !rnd_dly, 1'b0);
        end
        rnd_dly = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
